// File: rtl/dft_butterfly_addsub_if.sv
// Stream bus of the complex butterfly adder: operand beat in, sum/diff beat out.
// master drives operands and out_ready; slave is the butterfly itself.
interface dft_butterfly_addsub_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              scale;
  logic [DATA_W-1:0] a_re;
  logic [DATA_W-1:0] a_im;
  logic [DATA_W-1:0] b_re;
  logic [DATA_W-1:0] b_im;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] sum_re;
  logic [DATA_W-1:0] sum_im;
  logic [DATA_W-1:0] diff_re;
  logic [DATA_W-1:0] diff_im;
  logic              sat;

  modport master (
    output in_valid, scale, a_re, a_im, b_re, b_im, out_ready,
    input  in_ready, out_valid, sum_re, sum_im, diff_re, diff_im, sat
  );

  modport slave (
    input  in_valid, scale, a_re, a_im, b_re, b_im, out_ready,
    output in_ready, out_valid, sum_re, sum_im, diff_re, diff_im, sat
  );
endinterface

// File: rtl/dft_butterfly_addsub.sv
// Pipelined complex radix-2 butterfly: A+B and A-B per beat, optional
// halving with round-half-up, saturation with per-beat and sticky flags.
// Whole pipeline advances together on en = !out_valid || out_ready.
module dft_butterfly_addsub #(
  parameter int DATA_W      = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dft_butterfly_addsub_if.slave bus,
  input  logic                  ovf_clr,
  output logic                  ovf
);
  localparam int unsigned N = PIPE_STAGES;

  // Two guard bits: one for the add/sub growth, one for the +1 rounding term.
  typedef logic signed [DATA_W+1:0] wide_t;

  localparam wide_t MAXV = {3'b000, {(DATA_W-1){1'b1}}};
  localparam wide_t MINV = {3'b111, {(DATA_W-1){1'b0}}};

  // Returns {clamped, result}; a scaled value always fits, so never clamps.
  function automatic logic [DATA_W:0] fix(input wide_t x, input logic sc);
    wide_t            r;
    logic [DATA_W:0]  o;
    r = (x + wide_t'(1)) >>> 1;
    if (sc)            o = {1'b0, r[DATA_W-1:0]};
    else if (x > MAXV) o = {1'b1, MAXV[DATA_W-1:0]};
    else if (x < MINV) o = {1'b1, MINV[DATA_W-1:0]};
    else               o = {1'b0, x[DATA_W-1:0]};
    return o;
  endfunction

  logic [DATA_W-1:0] sre_q [N];
  logic [DATA_W-1:0] sim_q [N];
  logic [DATA_W-1:0] dre_q [N];
  logic [DATA_W-1:0] dim_q [N];
  logic              sat_q [N];
  logic              v_q   [N];

  wide_t           ar, ai, br, bi;
  logic [DATA_W:0] fs_re, fs_im, fd_re, fd_im;
  logic            beat_sat;
  logic            en;

  // Stage-1 arithmetic on sign-extended operands.
  always_comb begin
    ar       = wide_t'($signed(bus.a_re));
    ai       = wide_t'($signed(bus.a_im));
    br       = wide_t'($signed(bus.b_re));
    bi       = wide_t'($signed(bus.b_im));
    fs_re    = fix(ar + br, bus.scale);
    fs_im    = fix(ai + bi, bus.scale);
    fd_re    = fix(ar - br, bus.scale);
    fd_im    = fix(ai - bi, bus.scale);
    beat_sat = fs_re[DATA_W] | fs_im[DATA_W] | fd_re[DATA_W] | fd_im[DATA_W];
  end

  assign en           = !v_q[N-1] || bus.out_ready;
  assign bus.in_ready = en;

  // Pipeline registers: stage 0 captures results, later stages are pure delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        sre_q[i] <= '0;
        sim_q[i] <= '0;
        dre_q[i] <= '0;
        dim_q[i] <= '0;
        sat_q[i] <= 1'b0;
        v_q[i]   <= 1'b0;
      end
    end else if (en) begin
      sre_q[0] <= fs_re[DATA_W-1:0];
      sim_q[0] <= fs_im[DATA_W-1:0];
      dre_q[0] <= fd_re[DATA_W-1:0];
      dim_q[0] <= fd_im[DATA_W-1:0];
      sat_q[0] <= bus.in_valid & beat_sat;
      v_q[0]   <= bus.in_valid;
      for (int unsigned i = 1; i < N; i++) begin
        sre_q[i] <= sre_q[i-1];
        sim_q[i] <= sim_q[i-1];
        dre_q[i] <= dre_q[i-1];
        dim_q[i] <= dim_q[i-1];
        sat_q[i] <= sat_q[i-1];
        v_q[i]   <= v_q[i-1];
      end
    end
  end

  assign bus.out_valid = v_q[N-1];
  assign bus.sum_re    = sre_q[N-1];
  assign bus.sum_im    = sim_q[N-1];
  assign bus.diff_re   = dre_q[N-1];
  assign bus.diff_im   = dim_q[N-1];
  assign bus.sat       = sat_q[N-1];

  // Sticky overflow: a consumed saturated beat sets it and beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  ovf <= 1'b0;
    else if (v_q[N-1] && bus.out_ready && sat_q[N-1]) ovf <= 1'b1;
    else if (ovf_clr)                            ovf <= 1'b0;
  end
endmodule

// File: tb/tb_dft_butterfly_addsub.sv
// Scoreboard bench for the butterfly adder: driver pushes model results on
// each accepted beat, a monitor pops and compares on each consumed beat.
module tb_dft_butterfly_addsub;
  localparam int DW = 16;
  localparam int P  = 2;
  localparam int P4 = 4;
  localparam int MAXI = 32767;
  localparam int MINI = -32768;

  logic clk = 1'b0;
  logic rst_n;
  logic ovf_clr, ovf, ovf4;
  always #5 clk = ~clk;

  dft_butterfly_addsub_if #(.DATA_W(DW)) bus ();
  dft_butterfly_addsub_if #(.DATA_W(DW)) bus4 ();

  dft_butterfly_addsub #(.DATA_W(DW), .PIPE_STAGES(P)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ovf_clr(ovf_clr), .ovf(ovf));

  dft_butterfly_addsub #(.DATA_W(DW), .PIPE_STAGES(P4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .ovf_clr(1'b0), .ovf(ovf4));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sre; int sim; int dre; int dim;
    bit sat; int acc; bit lat;
  } exp_t;
  exp_t sb[$];

  int rdy_mode = 0;   // 0 fixed, 1 pattern, 2 random
  bit rdy_fix  = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, then floor((x+1)/2) or a clamp to the range.
  function automatic int ref_val(input int x, input bit sc);
    int y, q;
    if (sc) begin
      y = x + 1;
      q = y / 2;
      if (y < 0 && (y % 2) != 0) q = q - 1;
      return q;
    end
    if (x > MAXI) return MAXI;
    if (x < MINI) return MINI;
    return x;
  endfunction

  function automatic bit clamps(input int x);
    return (x > MAXI) || (x < MINI);
  endfunction

  function automatic exp_t model(input int ar, input int ai, input int br,
                                 input int bi, input bit sc);
    exp_t e;
    e.sre = ref_val(ar + br, sc);
    e.sim = ref_val(ai + bi, sc);
    e.dre = ref_val(ar - br, sc);
    e.dim = ref_val(ai - bi, sc);
    e.sat = !sc && (clamps(ar + br) || clamps(ai + bi) ||
                    clamps(ar - br) || clamps(ai - bi));
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Present one beat from the next falling edge until it is accepted.
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input bit sc, input bit lat);
    int   n;
    bit   done;
    exp_t e;
    n = 0;
    done = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.scale    = sc;
    bus.a_re     = ar[DW-1:0];
    bus.a_im     = ai[DW-1:0];
    bus.b_re     = br[DW-1:0];
    bus.b_im     = bi[DW-1:0];
    while (!done) begin
      #4;
      if (bus.in_ready) begin
        e     = model(ar, ai, br, bi, sc);
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
        done  = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          checks++; errors++;
          $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #4;
      n++;
    end while (!bus.out_valid && n < 50);
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL wait_out_timeout: out_valid 0 after %0d cycles", n);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // out_ready source, updated just after each falling edge.
  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  initial begin
    int pi;
    pi = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      case (rdy_mode)
        1:       begin bus.out_ready = pat[pi % 7] != 0; pi++; end
        2:       bus.out_ready = $urandom_range(0, 1) != 0;
        default: bus.out_ready = rdy_fix;
      endcase
    end
  end

  // Monitor: handshake, stall stability and scoreboard comparison.
  exp_t              me;
  bit                prev_stall = 1'b0;
  bit                stall_now;
  logic [DW-1:0]     hs_re, hs_im, hd_re, hd_im;
  logic              h_sat;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        stall_now = bus.out_valid && !bus.out_ready;
        chk("in_ready_vs_stall", longint'(bus.in_ready), longint'(!stall_now));
        if (prev_stall) begin
          chk("stall_hold_valid", longint'(bus.out_valid), 1);
          chk("stall_hold_sum_re", longint'(bus.sum_re), longint'(hs_re));
          chk("stall_hold_sum_im", longint'(bus.sum_im), longint'(hs_im));
          chk("stall_hold_diff_re", longint'(bus.diff_re), longint'(hd_re));
          chk("stall_hold_diff_im", longint'(bus.diff_im), longint'(hd_im));
          chk("stall_hold_sat", longint'(bus.sat), longint'(h_sat));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: out_valid with empty scoreboard, sum_re=%0d",
                     $signed(bus.sum_re));
          end else begin
            me = sb.pop_front();
            chk("sum_re",  longint'($signed(bus.sum_re)),  me.sre);
            chk("sum_im",  longint'($signed(bus.sum_im)),  me.sim);
            chk("diff_re", longint'($signed(bus.diff_re)), me.dre);
            chk("diff_im", longint'($signed(bus.diff_im)), me.dim);
            chk("sat",     longint'(bus.sat),              longint'(me.sat));
            if (me.lat) chk("latency", longint'(cyc - me.acc), P);
          end
        end
        hs_re = bus.sum_re;  hs_im = bus.sum_im;
        hd_re = bus.diff_re; hd_im = bus.diff_im;
        h_sat = bus.sat;
        prev_stall = stall_now;
      end
    end
  end

  // Bubble pattern through the 4-stage instance with out_ready held high.
  bit hist[40];
  initial begin
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    bus4.scale     = 1'b0;
    bus4.a_re = '0; bus4.a_im = '0; bus4.b_re = '0; bus4.b_im = '0;
    wait (rst_n === 1'b1);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      bus4.in_valid = (j % 2) == 0;
      bus4.a_re     = DW'($urandom);
      bus4.b_re     = DW'($urandom);
      hist[j]       = bus4.in_valid;
      #4;
      chk("bubble_out_valid", longint'(bus4.out_valid),
          (j >= P4) ? longint'(hist[j-P4]) : 0);
    end
    bus4.in_valid = 1'b0;
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    ovf_clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.scale    = 1'b0;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
    #22;
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_sat",       longint'(bus.sat), 0);
    chk("reset_ovf",       longint'(ovf), 0);
    chk("reset_sum_re",    longint'(bus.sum_re), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("in_ready_after_reset", longint'(bus.in_ready), 1);

    // basic beat, exact latency
    send(1000, -200, 300, 50, 1'b0, 1'b1);
    idle();
    wait_out();
    cycles(2);
    chk("ovf_idle", longint'(ovf), 0);

    // saturation and sticky ovf with a coincident clear
    send(32767, -32768, 1, 1, 1'b0, 1'b1);
    idle();
    wait_out();
    ovf_clr = 1'b1;
    chk("ovf_before_consume", longint'(ovf), 0);
    @(negedge clk);
    ovf_clr = 1'b0;
    #4;
    chk("ovf_set_wins", longint'(ovf), 1);
    @(negedge clk);
    #4;
    chk("ovf_sticky", longint'(ovf), 1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #4;
    chk("ovf_cleared", longint'(ovf), 0);

    // scaling, back to back
    send(32767, -32768, 32767, -32768, 1'b1, 1'b1);
    send(3, -3, 0, 0, 1'b1, 1'b1);
    idle();
    cycles(5);

    // backpressure with the fixed ready pattern
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      send(100 * i + 1, -50 * i, 7 * i, 3 * i - 11, 1'b0, 1'b0);
    idle();
    cycles(10);

    // randomized traffic with random ready
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 1) != 0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rdy_mode = 0;
    rdy_fix  = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", longint'(sb.size()), 0);

    // asynchronous reset with two beats held in flight
    rdy_fix = 1'b0;
    cycles(2);
    send(32767, 0, 1, 0, 1'b0, 1'b0);
    send(5, 5, 5, 5, 1'b0, 1'b0);
    idle();
    #1;
    chk("pre_reset_out_valid", longint'(bus.out_valid), 1);
    chk("pre_reset_sat",       longint'(bus.sat), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", longint'(bus.out_valid), 0);
    chk("async_rst_sat",       longint'(bus.sat), 0);
    chk("async_rst_ovf",       longint'(ovf), 0);
    chk("async_rst_sum_re",    longint'(bus.sum_re), 0);
    chk("async_rst_diff_re",   longint'(bus.diff_re), 0);
    sb.delete();
    rdy_fix = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("in_ready_after_rerelease", longint'(bus.in_ready), 1);
    send(7, 8, 9, 10, 1'b0, 1'b1);
    idle();
    cycles(8);
    chk("final_scoreboard_empty", longint'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
